ahb_lite_copy_master: RTL
=========================

Name: ahb_lite_copy_master

Overview:
- AHB-Lite initiator (bus master) that moves 32-bit words between memory-mapped regions, e.g. system RAM to the GPU framebuffer slave.
- Two modes, selected per command from a start/busy/done interface driven by the CPU-side control registers:
  - copy: read the source word, then write it to the destination.
  - fill: write a constant to the destination, with no reads.
- Issues only SINGLE, word-size, non-overlapped transfers, so any AHB-Lite subordinate on the fabric is a legal target.

Parameters:
- LEN_WIDTH, 16, width of the word-count field; maximum transfer is 2^LEN_WIDTH-1 words.
- HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged, data).

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESET  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle command strobe; sampled only when busy=0.
- fillMode  in  1  at start: 1=fill, 0=copy.
- srcAddr  in  32  source byte address; bits [1:0] are ignored and treated as 0.
- dstAddr  in  32  destination byte address; bits [1:0] are ignored and treated as 0.
- lenWords  in  LEN_WIDTH  number of words to transfer.
- fillData  in  32  fill value, captured at start.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when the command completes successfully.
- error  out  1  sticky; set on an HRESP error, cleared by the next accepted start.
- HADDR  out  32  bus address.
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- HWRITE  out  1  1=write transfer.
- HSIZE  out  3  fixed 3'b010.
- HBURST  out  3  fixed 3'b000.
- HPROT  out  4  fixed HPROT_VAL.
- HWDATA  out  32  write data, valid in the write data phase.
- HREADY  in  1  transfer-done / wait-state from the interconnect.
- HRDATA  in  32  read data.
- HRESP  in  1  1=ERROR.

Behaviour:
- Reset values: busy=0, done=0, error=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0; state=IDLE.
- Reset asserted mid-command: the bus returns to IDLE at that edge and no done pulse is generated. The subordinate may still see a truncated data phase; this is accepted.
- All state is registered: counters srcPtr, dstPtr, remain; registers dataBuf, mode.
- State machine:
  - IDLE:
    - If start=1, latch the pointers (with [1:0] forced to 0), remain=lenWords, mode=fillMode, dataBuf=fillData, clear error, set busy.
    - Next state if lenWords=0: DONE.
    - Next state otherwise: WR_A if fill, else RD_A.
  - RD_A: drive HTRANS=NONSEQ, HWRITE=0, HADDR=srcPtr. Held unchanged while HREADY=0. On HREADY=1 go to RD_D.
  - RD_D: drive HTRANS=IDLE. Wait for HREADY=1, then dataBuf<=HRDATA, srcPtr+=4, and go to WR_A.
  - WR_A: drive HTRANS=NONSEQ, HWRITE=1, HADDR=dstPtr. Held while HREADY=0. On HREADY=1 go to WR_D.
  - WR_D: drive HTRANS=IDLE and HWDATA=dataBuf, held stable until HREADY=1. Then dstPtr+=4 and remain-=1.
    - If remain was 1: go to DONE.
    - Otherwise: go to RD_A (copy) or WR_A (fill).
  - DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
  - ERR: busy=0, go to IDLE.
- Error handling: HRESP=1 in RD_D or WR_D (first error cycle, HREADY=0):
  - Set error.
  - HTRANS stays IDLE.
  - On the HREADY=1 of the second error cycle go to ERR.
  - dataBuf is not written, the pointers do not advance, and done is not pulsed.
- Pointer arithmetic is modulo 2^32; wrap from 0xFFFFFFFC to 0x00000000 is legal and silent.
- start while busy=1 is ignored, and the command inputs are not re-sampled.
- Minimum, zero-wait-state cost:
  - copy: 4 cycles per word (A, D, A, D).
  - fill: 2 cycles per word.
  - Command overhead: IDLE to first address = 1 cycle; last data to done = 1 cycle.
- HADDR and HWRITE in the data-phase states hold the last address-phase values; they are don't-care to the bus.

Test Plan:
- Copy, zero waits: src=0x1000, dst=0x2000, len=3, memory model returns 0xA0+i.
  - Required: 3 NONSEQ reads then writes, alternating.
  - Required: writes to 0x2000/4/8 with data 0xA0/A1/A2.
  - Required: done is pulsed at cycle 1+12+1 after start; busy is high throughout.
- Fill with waits: fill, dst=0x3002, len=2, fillData=0xDEADBEEF, slave inserts 2 wait states per data phase.
  - Required: addresses 0x3000 and 0x3004.
  - Required: HWDATA stable across the waits.
  - Required: no read transfers.
- Wait in address phase: HREADY=0 during RD_A for 3 cycles.
  - Required: HADDR/HTRANS/HWRITE unchanged until HREADY=1; transfer count is still exact.
- Error response: slave returns ERROR on the second read of a len=4 copy.
  - Required: error=1, busy falls, done never pulses, exactly 1 write is issued.
  - Then a new start: error clears and the transfer completes.
- Edge cases:
  - len=0: done at cycle 2, no HTRANS=NONSEQ.
  - start during busy: ignored.
  - dst=0xFFFFFFFC with len=2: second write goes to 0x00000000.
  - HRESET during a WR_D wait: all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/ahb_lite_copy_master.sv
// AHB-Lite bus master that copies or fills 32-bit words between memory regions.
// Only SINGLE, word-size, non-overlapped transfers are issued, so every
// AHB-Lite subordinate is a legal target. Bus outputs are registered from the
// next state, so they line up with the state register.
module ahb_lite_copy_master #(
  parameter int unsigned LEN_WIDTH = 16,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 start,
  input  logic                 fillMode,
  input  logic [31:0]          srcAddr,
  input  logic [31:0]          dstAddr,
  input  logic [LEN_WIDTH-1:0] lenWords,
  input  logic [31:0]          fillData,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic [31:0]          HWDATA,
  input  logic                 HREADY,
  input  logic [31:0]          HRDATA,
  input  logic                 HRESP
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [AW-1:0] WORD_BYTES    = AW'(4);
  localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]    HSIZE_WORD    = 3'b010;
  localparam logic [2:0]    HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_D = 3'd2,
    S_WR_A = 3'd3,
    S_WR_D = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // State and datapath registers
  state_t               r_state;
  logic [AW-1:0]        r_src_ptr;
  logic [AW-1:0]        r_dst_ptr;
  logic [LEN_WIDTH-1:0] r_remain;
  logic [DW-1:0]        r_data_buf;
  logic                 r_mode;
  logic                 r_error;
  logic                 r_busy;
  logic                 r_done;
  logic [AW-1:0]        r_haddr;
  logic [1:0]           r_htrans;
  logic                 r_hwrite;
  logic [DW-1:0]        r_hwdata;

  // Next-state values
  state_t               w_state_nxt;
  logic [AW-1:0]        w_src_nxt;
  logic [AW-1:0]        w_dst_nxt;
  logic [LEN_WIDTH-1:0] w_remain_nxt;
  logic [DW-1:0]        w_data_buf_nxt;
  logic                 w_mode_nxt;
  logic                 w_error_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [AW-1:0]        w_haddr_nxt;
  logic [1:0]           w_htrans_nxt;
  logic                 w_hwrite_nxt;
  logic [DW-1:0]        w_hwdata_nxt;

  // Byte-lane bits of the start addresses are forced to zero and never read.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{srcAddr[1:0], dstAddr[1:0]};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_src_nxt      = r_src_ptr;
    w_dst_nxt      = r_dst_ptr;
    w_remain_nxt   = r_remain;
    w_data_buf_nxt = r_data_buf;
    w_mode_nxt     = r_mode;
    w_error_nxt    = r_error;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_haddr_nxt    = r_haddr;
    w_htrans_nxt   = HTRANS_IDLE;
    w_hwrite_nxt   = r_hwrite;
    w_hwdata_nxt   = r_hwdata;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src_nxt      = {srcAddr[AW-1:2], 2'b00};
          w_dst_nxt      = {dstAddr[AW-1:2], 2'b00};
          w_remain_nxt   = lenWords;
          w_mode_nxt     = fillMode;
          w_data_buf_nxt = fillData;
          w_error_nxt    = 1'b0;
          if (lenWords == '0) begin
            w_state_nxt = S_DONE;
          end else if (fillMode) begin
            w_state_nxt = S_WR_A;
          end else begin
            w_state_nxt = S_RD_A;
          end
        end
      end

      S_RD_A: begin
        if (HREADY) begin
          w_state_nxt = S_RD_D;
        end
      end

      S_RD_D: begin
        // First ERROR cycle has HREADY=0; the abort happens on the second.
        if (HRESP) begin
          w_error_nxt = 1'b1;
          if (HREADY) begin
            w_state_nxt = S_ERR;
          end
        end else if (HREADY) begin
          w_data_buf_nxt = HRDATA;
          w_src_nxt      = r_src_ptr + WORD_BYTES;
          w_state_nxt    = S_WR_A;
        end
      end

      S_WR_A: begin
        if (HREADY) begin
          w_state_nxt = S_WR_D;
        end
      end

      S_WR_D: begin
        if (HRESP) begin
          w_error_nxt = 1'b1;
          if (HREADY) begin
            w_state_nxt = S_ERR;
          end
        end else if (HREADY) begin
          w_dst_nxt    = r_dst_ptr + WORD_BYTES;
          w_remain_nxt = r_remain - LEN_WIDTH'(1);
          if (r_remain == LEN_WIDTH'(1)) begin
            w_state_nxt = S_DONE;
          end else if (r_mode) begin
            w_state_nxt = S_WR_A;
          end else begin
            w_state_nxt = S_RD_A;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      S_ERR: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs follow the state being entered; data-phase states hold address/direction.
    case (w_state_nxt)
      S_RD_A: begin
        w_htrans_nxt = HTRANS_NONSEQ;
        w_haddr_nxt  = w_src_nxt;
        w_hwrite_nxt = 1'b0;
        w_busy_nxt   = 1'b1;
      end
      S_WR_A: begin
        w_htrans_nxt = HTRANS_NONSEQ;
        w_haddr_nxt  = w_dst_nxt;
        w_hwrite_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
      end
      S_RD_D: begin
        w_busy_nxt = 1'b1;
      end
      S_WR_D: begin
        w_hwdata_nxt = w_data_buf_nxt;
        w_busy_nxt   = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointer, count and data-buffer registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_src_ptr  <= '0;
      r_dst_ptr  <= '0;
      r_remain   <= '0;
      r_data_buf <= '0;
      r_mode     <= 1'b0;
    end else begin
      r_src_ptr  <= w_src_nxt;
      r_dst_ptr  <= w_dst_nxt;
      r_remain   <= w_remain_nxt;
      r_data_buf <= w_data_buf_nxt;
      r_mode     <= w_mode_nxt;
    end
  end

  // Registered status and bus outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_error  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_haddr  <= '0;
      r_htrans <= HTRANS_IDLE;
      r_hwrite <= 1'b0;
      r_hwdata <= '0;
    end else begin
      r_error  <= w_error_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_haddr  <= w_haddr_nxt;
      r_htrans <= w_htrans_nxt;
      r_hwrite <= w_hwrite_nxt;
      r_hwdata <= w_hwdata_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign error  = r_error;
  assign HADDR  = r_haddr;
  assign HTRANS = r_htrans;
  assign HWRITE = r_hwrite;
  assign HWDATA = r_hwdata;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_VAL;

endmodule
